// File: rtl/vs4x400_pkg.sv
// Shared constants for the vs4x400 query/database pair packer.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
//
// Contents: default vector-memory address width, lane geometry of the
// 64-bit packed write word, packer FSM state encoding, and a helper that
// returns the number of 32-bit query words per vector.
package vs4x400_pkg;

  localparam int ADDR_W = 12;  // default vector-memory word-address width
  localparam int LANE_W = 16;  // one {db, query} byte pair per lane
  localparam int LANES  = 4;   // lanes per 64-bit write word

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_Q = 2'd1;
  localparam logic [1:0] ST_LOAD_D = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // ceil(dim / 4): write words needed to hold one vector.
  function automatic logic [6:0] words_for_dim(input logic [7:0] dim);
    return 7'((9'(dim) + 9'd3) >> 2);
  endfunction

endpackage

// File: rtl/vs4x400_query_buf.sv
// Query vector store: 64 words x 32 bits, byte-enable write, word-indexed read.
// Latency: write takes effect at the clock edge; read is combinational.
// Backpressure: none, accepts a write every cycle.
//
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - word index for the write
//   be_i     - per-byte write enables
//   wdata_i  - write data (only enabled bytes are stored)
//   raddr_i  - word index for the read
//   rdata_o  - read data
module vs4x400_query_buf
  import vs4x400_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [5:0]       waddr_i,
  input  logic [LANES-1:0] be_i,
  input  logic [31:0]      wdata_i,
  input  logic [5:0]       raddr_i,
  output logic [31:0]      rdata_o
);

  // No reset: contents are always written before being read in a load.
  logic [31:0] mem_q [64];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < LANES; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vs4x400_pair_packer.sv
// Loads a query vector, then packs each database vector with it into 64-bit pair words.
// Latency: a write word appears one cycle after its 4th byte; done one cycle after the last write.
// Backpressure: s_ready is high throughout a load (1 byte/cycle); s_valid=0 simply freezes progress.
//
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   load_start, cfg_dim_size,
//   cfg_vector_count               - start a load; config sampled on the start cycle in IDLE
//   s_valid, s_data, s_ready       - int8 byte stream: dim query bytes, then count*dim db bytes
//   wr_en, wr_addr, wr_data        - vector-memory write port (lane k = {db, query} at bits 16k+15:16k)
//   busy, done, err                - load in progress, one-cycle completion pulse, sticky config error
//
// Build option: define VS4X400_PACKER_ZERO_PAD_EN to accept dims that are not a
// multiple of 4; unused lanes of each vector's last word are written as zero.
module vs4x400_pair_packer #(
  parameter int ADDR_W  = vs4x400_pkg::ADDR_W,
  parameter int MAX_DIM = 252
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        cfg_dim_size,
  input  logic [9:0]        cfg_vector_count,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import vs4x400_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [7:0]        dim_q, dim_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d;    // byte index within the current vector
  logic [9:0]        vec_q, vec_d;      // database vector index
  logic [31:0]       db_q, db_d;        // db bytes of the word being assembled
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [63:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // ---------------- configuration check ----------------
  logic [6:0]  cfg_words;
  logic [32:0] cfg_total;
  logic [32:0] addr_space;
  logic        dim_unaligned;
  logic        cfg_bad;

  assign cfg_words  = words_for_dim(cfg_dim_size);
  assign cfg_total  = 33'(cfg_vector_count) * 33'(cfg_words);
  assign addr_space = 33'd1 << ADDR_W;

`ifdef VS4X400_PACKER_ZERO_PAD_EN
  assign dim_unaligned = 1'b0;
`else
  assign dim_unaligned = |cfg_dim_size[1:0];
`endif

  assign cfg_bad = (cfg_dim_size == 8'd0)
                || (int'(cfg_dim_size) > MAX_DIM)
                || (cfg_vector_count == 10'd0)
                || (cfg_total > addr_space)
                || dim_unaligned;

  // ---------------- datapath ----------------
  logic        xfer;
  logic        last_byte;
  logic        last_vec;
  logic [1:0]  lane;
  logic [31:0] q_word;
  logic [31:0] pack_db;
  logic [63:0] pack;

  assign s_ready   = (state_q == ST_LOAD_Q) || (state_q == ST_LOAD_D);
  assign xfer      = s_valid && s_ready;
  assign last_byte = (byte_q == dim_q - 8'd1);
  assign last_vec  = (vec_q == cnt_q - 10'd1);
  assign lane      = byte_q[1:0];

  vs4x400_query_buf u_qbuf (
    .clk     (clk),
    .we_i    (xfer && (state_q == ST_LOAD_Q)),
    .waddr_i (byte_q[7:2]),
    .be_i    (4'b0001 << lane),
    .wdata_i ({4{s_data}}),
    .raddr_i (byte_q[7:2]),
    .rdata_o (q_word)
  );

  // Assemble the outgoing word from the stored query word and the db bytes
  // collected so far plus the byte on the bus. Lanes above the current one
  // only exist on a short last word, and are forced to zero there.
  always_comb begin
    pack_db = db_q;
    pack_db[{lane, 3'b000} +: 8] = s_data;
    pack = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k <= int'(lane)) begin
        pack[LANE_W*k +: 8]     = q_word[8*k +: 8];
        pack[LANE_W*k + 8 +: 8] = pack_db[8*k +: 8];
      end
    end
  end

  // ---------------- control ----------------
  always_comb begin
    state_d   = state_q;
    dim_d     = dim_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    vec_d     = vec_q;
    db_d      = db_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    // The address advances once the write it labels has been presented.
    addr_d    = wr_en_q ? addr_q + ADDR_W'(1) : addr_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            busy_d  = 1'b1;
            dim_d   = cfg_dim_size;
            cnt_d   = cfg_vector_count;
            byte_d  = 8'd0;
            vec_d   = 10'd0;
            addr_d  = '0;
            state_d = ST_LOAD_Q;
          end
        end
      end

      ST_LOAD_Q: begin
        if (xfer) begin
          if (last_byte) begin
            byte_d  = 8'd0;
            state_d = ST_LOAD_D;
          end else begin
            byte_d = byte_q + 8'd1;
          end
        end
      end

      ST_LOAD_D: begin
        if (xfer) begin
          db_d = pack_db;
          if ((lane == 2'd3) || last_byte) begin
            wr_en_d   = 1'b1;
            wr_data_d = pack;
          end
          if (last_byte) begin
            byte_d = 8'd0;
            if (last_vec) begin
              state_d = ST_DONE;
            end else begin
              vec_d = vec_q + 10'd1;
            end
          end else begin
            byte_d = byte_q + 8'd1;
          end
        end
      end

      ST_DONE: begin
        // The final write is on the port this cycle; done follows it.
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dim_q     <= 8'd0;
      cnt_q     <= 10'd0;
      byte_q    <= 8'd0;
      vec_q     <= 10'd0;
      db_q      <= 32'd0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 64'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dim_q     <= dim_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      vec_q     <= vec_d;
      db_q      <= db_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: doc/vs4x400_pair_packer.md
VS4X400_PAIR_PACKER -- requirements
Module: vs4x400_pair_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, vector-memory word-address width.
REQ-002 SHALL have parameter MAX_DIM, default 252, largest accepted cfg_dim_size.
REQ-003 SHALL have ports `clk` (in, 1, clock) and `reset` (in, 1, asynchronous, active-high).
REQ-004 SHALL have ports `load_start` (in, 1, begin load) and `cfg_dim_size` (in, 8, int8 elements per vector).
REQ-005 SHALL have port `cfg_vector_count` (in, 10, database vectors to load).
REQ-006 SHALL have ports `s_valid` (in, 1), `s_data` (in, 8, signed int8 element) and `s_ready` (out, 1).
REQ-007 SHALL have ports `wr_en` (out, 1), `wr_addr` (out, ADDR_W) and `wr_data` (out, 64), forming the vector-memory write port.
REQ-008 SHALL have ports `busy` (out, 1), `done` (out, 1, one-cycle pulse) and `err` (out, 1, sticky config error).

Function
REQ-009 SHALL implement FSM states IDLE, LOAD_Q, LOAD_D and DONE.
REQ-010 SHALL sample cfg_* on the load_start cycle in IDLE, and SHALL ignore load_start in all other states.
REQ-011 SHALL treat these as config errors: dim=0, dim>MAX_DIM, count=0, or count*ceil(dim/4) > 2^ADDR_W.
REQ-012 On a config error SHALL set err, remain in IDLE and perform no writes.
REQ-013 On a valid config SHALL clear err, assert busy and go to LOAD_Q.
REQ-014 A byte SHALL transfer only on a cycle with s_valid&&s_ready; s_ready SHALL be 1 only in LOAD_Q and LOAD_D.
REQ-015 LOAD_Q SHALL store dim query bytes into the query buffer in order, then go to LOAD_D.
REQ-016 LOAD_D SHALL pack each group of 4 database bytes with query bytes 4w..4w+3, where w is the word index within the vector.
REQ-017 Lane k (k=0..3) SHALL place the query byte at wr_data[16k+7:16k] and the db byte at wr_data[16k+15:16k+8].
REQ-018 wr_en SHALL pulse exactly one cycle, registered, on the cycle after the 4th byte of a word is accepted.
REQ-019 wr_addr SHALL start at 0 per load and increment by 1 per write, with no gaps between vectors.
REQ-020 After the final word of vector count-1, the FSM SHALL go to DONE.
REQ-021 DONE SHALL pulse done for one cycle, deassert busy, and return to IDLE.
REQ-022 done SHALL coincide with the cycle after the last wr_en.
REQ-023 Back-to-back streaming SHALL sustain 1 byte/cycle with no stalls.
REQ-024 Idle cycles (s_valid=0) SHALL freeze all counters.

Reset
REQ-025 On reset SHALL go to IDLE with busy=0, done=0, err=0, wr_en=0, wr_addr=0, s_ready=0, and all counters 0.
REQ-026 Reset mid-load SHALL abort the load immediately with no further writes; query buffer contents are don't-care.

Configuration
REQ-027 With VS4X400_PACKER_ZERO_PAD_EN defined, dim%4 != 0 SHALL be accepted, and the last word of each vector SHALL carry zero query and zero db bytes in unused lanes.
REQ-028 With the macro undefined, dim%4 != 0 SHALL be a config error per REQ-012.

Structure
REQ-029 Package vs4x400_pkg SHALL hold ADDR_W, the lane-width constant (16), the lane count (4) and the FSM state encoding.
REQ-030 Sub-module vs4x400_query_buf SHALL be a 64x32-bit buffer with byte-enable synchronous write and combinational 32-bit read, indexed by word.

Verification
REQ-031 Bench SHALL cover: dim=8, count=2, query bytes 1..8, db bytes 10..25 streamed continuously -> 4 writes at addr 0..3; word0 = {8'd13,8'd4,8'd12,8'd3,8'd11,8'd2,8'd10,8'd1}; done pulses once.
REQ-032 Bench SHALL cover: the same stream with s_valid toggled every other cycle -> identical write sequence, longer latency, no duplicate writes.
REQ-033 Bench SHALL cover: dim=252, count=1000 -> err=1, no wr_en, busy stays 0; a subsequent valid load clears err.
REQ-034 Bench SHALL cover: dim=6, count=1 -> with the macro defined, 2 writes, word1 lanes 2-3 zero; without the macro, err=1.
REQ-035 Bench SHALL cover: reset asserted after the 5th db byte -> outputs at reset values the same cycle, no further wr_en, a next load starts at addr 0.
REQ-036 Bench SHALL cover: load_start asserted while busy -> ignored, and the in-flight load completes unchanged.
